// File: rtl/gb_audio_pkg.sv
// Shared GameBoy audio constants and types for the I2S transmit path.
package gb_audio_pkg;
  localparam int GB_CLK_DIV  = 4;
  localparam int GB_SAMPLE_W = 16;
  localparam int GB_SLOT_W   = 16;

  typedef logic [15:0] sample_t;

  // Width of the frame bit index b, which spans 0..2*slot_w-1.
  function automatic int bidx_w(input int slot_w);
    return (2 * slot_w > 1) ? $clog2(2 * slot_w) : 1;
  endfunction

  localparam int GB_BIDX_W = bidx_w(GB_SLOT_W);
endpackage

// File: rtl/gb_i2s_clkgen.sv
// I2S timing generator: clock divider, BCLK, falling-edge strobe, frame bit index and LRCLK.
module gb_i2s_clkgen
  import gb_audio_pkg::*;
#(
  parameter int CLK_DIV = GB_CLK_DIV,
  parameter int SLOT_W  = GB_SLOT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bclk,
  output logic lrclk,
  output logic fall,
  output logic wrap
);
  localparam int BW = bidx_w(SLOT_W);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] B_LAST   = BW'(2 * SLOT_W - 1);
  localparam logic [BW-1:0] LR_LO    = BW'(SLOT_W - 1);
  localparam logic [BW-1:0] LR_HI    = BW'(2 * SLOT_W - 2);

  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bidx;
  logic [BW-1:0] bidx_nxt;
  logic          tc;

  assign tc       = en && (div_cnt == DIV_LAST);
  assign fall     = tc && bclk;
  assign wrap     = fall && (bidx == B_LAST);
  assign bidx_nxt = wrap ? '0 : bidx + BW'(1);

  // Idle (disabled) parks b on the last bit so the first fall after enable starts a frame.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      lrclk   <= 1'b0;
      bidx    <= B_LAST;
    end else begin
      div_cnt <= tc ? '0 : div_cnt + DW'(1);
      if (tc) bclk <= ~bclk;
      if (fall) begin
        bidx  <= bidx_nxt;
        lrclk <= (bidx_nxt >= LR_LO) && (bidx_nxt <= LR_HI);
      end
    end
  end
endmodule

// File: rtl/gb_i2s_tx.sv
// GameBoy stereo PCM to I2S serializer with one-entry holding buffer per channel.
// Optional GB_I2S_UNDERRUN_CNT_EN adds a saturating underrun counter port.
module gb_i2s_tx
  import gb_audio_pkg::*;
#(
  parameter int CLK_DIV  = GB_CLK_DIV,
  parameter int SAMPLE_W = GB_SAMPLE_W,
  parameter int SLOT_W   = GB_SLOT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] left_data,
  input  logic                left_valid,
  output logic                left_ready,
  input  logic [SAMPLE_W-1:0] right_data,
  input  logic                right_valid,
  output logic                right_ready,
  output logic                i2s_bclk,
  output logic                i2s_lrclk,
  output logic                i2s_sdata
`ifdef GB_I2S_UNDERRUN_CNT_EN
  ,
  output logic [15:0]         underrun_cnt
`endif
);
  localparam int FW = 2 * SLOT_W;

  // MSB-align a sample in its slot, zero-padding the LSBs.
  function automatic logic [SLOT_W-1:0] pad_slot(input logic [SAMPLE_W-1:0] s);
    return SLOT_W'(s) << (SLOT_W - SAMPLE_W);
  endfunction

  logic                bclk_fall;
  logic                frame_wrap;
  logic                left_full, right_full, both_full;
  logic [SAMPLE_W-1:0] left_buf, right_buf;
  logic [SAMPLE_W-1:0] left_last, right_last;
  logic [FW-1:0]       shift_sr;

  gb_i2s_clkgen #(
    .CLK_DIV (CLK_DIV),
    .SLOT_W  (SLOT_W)
  ) u_clkgen (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .bclk  (i2s_bclk),
    .lrclk (i2s_lrclk),
    .fall  (bclk_fall),
    .wrap  (frame_wrap)
  );

  assign left_ready  = ~left_full;
  assign right_ready = ~right_full;
  assign both_full   = left_full && right_full;
  assign i2s_sdata   = shift_sr[FW-1];

  // Holding buffers: a channel is only emptied by a frame load, only filled while empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      left_full  <= 1'b0;
      right_full <= 1'b0;
    end else begin
      if (frame_wrap && both_full) begin
        left_full  <= 1'b0;
        right_full <= 1'b0;
      end
      if (left_valid && !left_full)   left_full  <= 1'b1;
      if (right_valid && !right_full) right_full <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (left_valid && !left_full)   left_buf  <= left_data;
    if (right_valid && !right_full) right_buf <= right_data;
  end

  // Frame shift register: load a fresh pair, or replay the last pair on underrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_sr   <= '0;
      left_last  <= '0;
      right_last <= '0;
    end else if (frame_wrap) begin
      if (both_full) begin
        shift_sr   <= {pad_slot(left_buf), pad_slot(right_buf)};
        left_last  <= left_buf;
        right_last <= right_buf;
      end else begin
        shift_sr <= {pad_slot(left_last), pad_slot(right_last)};
      end
    end else if (!en) begin
      shift_sr <= '0;
    end else if (bclk_fall) begin
      shift_sr <= {shift_sr[FW-2:0], 1'b0};
    end
  end

`ifdef GB_I2S_UNDERRUN_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) underrun_cnt <= '0;
    else if (frame_wrap && !both_full) underrun_cnt <= sat_inc(underrun_cnt);
  end
`endif
endmodule

// File: tb/tb_gb_i2s_tx.sv
// Self-checking bench for gb_i2s_tx: per-cycle pin model plus captured-frame table checks.
module tb_gb_i2s_tx;
  localparam int CLK_DIV  = 4;
  localparam int SAMPLE_W = 16;
  localparam int SLOT_W   = 16;
  localparam int FIRST    = 2 * CLK_DIV;
  localparam int FRAME    = 4 * CLK_DIV * SLOT_W;

  logic        clk = 1'b0;
  logic        rst, en, lv, rv;
  logic [15:0] ld, rd;
  logic        lr, rr, bclk, lrclk, sdata;
`ifdef GB_I2S_UNDERRUN_CNT_EN
  logic [15:0] ucnt;
`endif

  always #5 clk = ~clk;

  gb_i2s_tx #(
    .CLK_DIV  (CLK_DIV),
    .SAMPLE_W (SAMPLE_W),
    .SLOT_W   (SLOT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .left_data    (ld),
    .left_valid   (lv),
    .left_ready   (lr),
    .right_data   (rd),
    .right_valid  (rv),
    .right_ready  (rr),
    .i2s_bclk     (bclk),
    .i2s_lrclk    (lrclk),
    .i2s_sdata    (sdata)
`ifdef GB_I2S_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (ucnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: enabled-cycle count, buffers, current frame word.
  int          m_n;
  bit          m_lf, m_rf, m_load;
  logic [15:0] m_bl, m_br, m_last_l, m_last_r;
  logic [31:0] m_frame;
  int          m_ur;
  int          m_b;

  // Pin-level deserializer (samples sdata on each BCLK rise).
  int          cap_r;
  logic [31:0] cap_w;
  logic [31:0] cap_q[$];
  logic        prev_bclk;

  typedef struct {
    bit          pl, pr;
    logic [15:0] l, r;
    logic [31:0] exp_frame;
    int          exp_ur;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    int  h, f;
    bit  pre_lf, pre_rf;
    logic e_bclk, e_lr, e_sd;
    @(posedge clk);
    m_load = 0;
    if (rst) begin
      m_n = 0; m_lf = 0; m_rf = 0; m_last_l = '0; m_last_r = '0;
      m_frame = '0; m_ur = 0;
    end else begin
      pre_lf = m_lf;
      pre_rf = m_rf;
      if (en) begin
        m_n++;
        m_load = (m_n >= FIRST) && (((m_n - FIRST) % FRAME) == 0);
      end else begin
        m_n = 0;
      end
      if (m_load) begin
        if (m_lf && m_rf) begin
          m_frame = {m_bl, m_br};
          m_last_l = m_bl; m_last_r = m_br;
          m_lf = 0; m_rf = 0;
        end else begin
          m_frame = {m_last_l, m_last_r};
          if (m_ur < 65535) m_ur++;
        end
      end
      if (lv && !pre_lf) begin m_bl = ld; m_lf = 1; end
      if (rv && !pre_rf) begin m_br = rd; m_rf = 1; end
    end
    h = m_n / CLK_DIV;
    f = h / 2;
    if (f == 0) begin
      m_b = 2 * SLOT_W - 1;
      e_sd = 1'b0;
    end else begin
      m_b = (f - 1) % (2 * SLOT_W);
      e_sd = m_frame[31 - m_b];
    end
    e_bclk = h[0];
    e_lr = (m_b >= SLOT_W - 1) && (m_b <= 2 * SLOT_W - 2);
    #1;
    check("pins{bclk,lrclk,sdata,lrdy,rrdy}", {27'd0, bclk, lrclk, sdata, lr, rr},
          {27'd0, e_bclk, e_lr, e_sd, !m_lf, !m_rf});
`ifdef GB_I2S_UNDERRUN_CNT_EN
    check("underrun_cnt_model", {16'd0, ucnt}, {16'd0, m_ur[15:0]});
`endif
    if (rst || !en) begin
      cap_r = 0;
    end else if (bclk && !prev_bclk) begin
      cap_r++;
      if (cap_r >= 2) begin
        cap_w = {cap_w[30:0], sdata};
        if (((cap_r - 2) % 32) == 31) cap_q.push_back(cap_w);
      end
    end
    prev_bclk = bclk;
  endtask

  task automatic push(input bit pl, input bit pr, input logic [15:0] l, input logic [15:0] r);
    if (pl) begin check("left_ready_before_push", {31'd0, lr}, 32'd1); lv = 1; ld = l; end
    if (pr) begin check("right_ready_before_push", {31'd0, rr}, 32'd1); rv = 1; rd = r; end
    tick();
    lv = 0; rv = 0;
  endtask

  task automatic wait_load(input string name);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!m_load && k < FRAME + FIRST + 4);
    if (!m_load) begin
      checks++; errors++;
      $display("FAIL %s: got no frame load after %0d cycles, expected one within %0d", name, k, FRAME + FIRST);
    end
  endtask

  initial begin
    tbl[0] = '{1, 1, 16'hA5F0, 16'h0F0F, 32'hA5F00F0F, 0};
    tbl[1] = '{0, 0, 16'h0000, 16'h0000, 32'hA5F00F0F, 1};
    tbl[2] = '{1, 0, 16'h1234, 16'h0000, 32'hA5F00F0F, 2};
    tbl[3] = '{0, 1, 16'h0000, 16'h5678, 32'h12345678, 2};
    tbl[4] = '{1, 1, 16'hFFFF, 16'h0001, 32'hFFFF0001, 2};
    tbl[5] = '{1, 1, 16'h8000, 16'h7FFF, 32'h80007FFF, 2};

    rst = 1; en = 0; lv = 0; rv = 0; ld = '0; rd = '0;
    prev_bclk = 1'b0; cap_r = 0; cap_w = '0;
    tick(); tick();
    check("reset_pins", {29'd0, bclk, lrclk, sdata}, 32'd0);
    check("reset_ready", {30'd0, lr, rr}, 32'd3);
`ifdef GB_I2S_UNDERRUN_CNT_EN
    check("reset_underrun", {16'd0, ucnt}, 32'd0);
`endif
    rst = 0;
    tick();

    // Table: one push pattern per frame, then compare captured frames.
    cap_q.delete();
    push(tbl[0].pl, tbl[0].pr, tbl[0].l, tbl[0].r);
    en = 1;
    for (int i = 0; i < 6; i++) begin
      wait_load("table_load");
`ifdef GB_I2S_UNDERRUN_CNT_EN
      check("table_underrun", {16'd0, ucnt}, tbl[i].exp_ur);
`endif
      if (i < 5) push(tbl[i+1].pl, tbl[i+1].pr, tbl[i+1].l, tbl[i+1].r);
    end
    wait_load("table_tail");
    check("table_frames_captured", cap_q.size(), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < cap_q.size()) check("table_frame", cap_q[i], tbl[i].exp_frame);

    // Valid held with changing data across three frames.
    lv = 1; rv = 1;
    for (int c = 0; c < 3 * FRAME; c++) begin
      ld = 16'($urandom); rd = 16'($urandom);
      tick();
    end
    lv = 0; rv = 0;

    // Reset in the middle of a frame at b=7 with a full buffer pair pending.
    wait_load("pre_reset_load");
    push(1, 1, 16'hDEAD, 16'hBEEF);
    for (int c = 0; c < FRAME && m_b != 7; c++) tick();
    check("reached_b7", m_b, 32'd7);
    rst = 1;
    tick();
    rst = 0;
    check("midreset_pins", {29'd0, bclk, lrclk, sdata}, 32'd0);
    check("midreset_ready", {30'd0, lr, rr}, 32'd3);
    cap_q.delete();
    wait_load("post_reset_load0");
`ifdef GB_I2S_UNDERRUN_CNT_EN
    check("post_reset_underrun", {16'd0, ucnt}, 32'd1);
`endif
    wait_load("post_reset_load1");
    check("post_reset_frames", cap_q.size(), 32'd1);
    if (cap_q.size() > 0) check("post_reset_frame_zero", cap_q[0], 32'd0);

    // Randomized producer cadence with an enable drop partway through.
    for (int c = 0; c < 6000; c++) begin
      lv = ($urandom_range(0, 15) == 0);
      rv = ($urandom_range(0, 15) == 0);
      ld = 16'($urandom); rd = 16'($urandom);
      en = !(c >= 3000 && c < 3037);
      tick();
    end
    lv = 0; rv = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
